// File: rtl/updown_step_ctrl_if.sv
// Button/step signal bundle between the pushbutton front end and its user.
// The master side drives the raw buttons; the slave side produces steps.
interface updown_step_ctrl_if;
    logic up_btn;
    logic down_btn;
    logic step;
    logic updown;
    logic locked;

    modport master (
        output up_btn,
        output down_btn,
        input  step,
        input  updown,
        input  locked
    );

    modport slave (
        input  up_btn,
        input  down_btn,
        output step,
        output updown,
        output locked
    );
endinterface

// File: rtl/updown_step_ctrl.sv
// Debounces the up/down pushbuttons and turns them into single-cycle step
// pulses with a held direction, auto-repeat while held, and a both-pressed lock.
module updown_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 8
) (
    input  logic              clk,
    input  logic              rst,
    updown_step_ctrl_if.slave bus
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX);
    localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RCNT_DELAY = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RCNT_RATE  = RW'(REPEAT_RATE - 1);
    localparam int UP = 0;
    localparam int DN = 1;

    typedef enum logic [1:0] {IDLE, HOLD_UP, HOLD_DN, LOCK} state_e;

    logic [1:0]    raw;
    logic [1:0]    s1_q, s1_d, s2_q, s2_d;
    logic [1:0]    db_q, db_d, db_prev_q, db_prev_d;
    logic [DW-1:0] dcnt_q [2];
    logic [DW-1:0] dcnt_d [2];
    state_e        state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          step_q, step_d;
    logic          updown_q, updown_d;
    logic          locked_q, locked_d;
    logic          up_rise, down_rise;

    assign raw = {bus.down_btn, bus.up_btn};

    // NOTE: every variable gets a default before any branch so always_comb never infers a latch.
    always_comb begin
        s1_d      = raw;
        s2_d      = s1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        for (int i = 0; i < 2; i++) begin
            dcnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (dcnt_q[i] == DCNT_LAST) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
                end
            end
        end
    end

    assign up_rise   = db_q[UP] & ~db_prev_q[UP];
    assign down_rise = db_q[DN] & ~db_prev_q[DN];

    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        step_d   = 1'b0;
        updown_d = updown_q;
        unique case (state_q)
            IDLE: begin
                if (db_q[UP] && db_q[DN]) begin
                    state_d = LOCK;
                end else if (up_rise) begin
                    state_d  = HOLD_UP;
                    step_d   = 1'b1;
                    updown_d = 1'b1;
                    rcnt_d   = RCNT_DELAY;
                end else if (down_rise) begin
                    state_d  = HOLD_DN;
                    step_d   = 1'b1;
                    updown_d = 1'b0;
                    rcnt_d   = RCNT_DELAY;
                end
            end
            HOLD_UP, HOLD_DN: begin
                // The held button and the opposing button swap roles between the two holds.
                if (!db_q[(state_q == HOLD_UP) ? UP : DN]) begin
                    state_d = IDLE;
                end else if (db_q[(state_q == HOLD_UP) ? DN : UP]) begin
                    state_d = LOCK;
                end else if (rcnt_q == '0) begin
                    step_d   = 1'b1;
                    updown_d = (state_q == HOLD_UP);
                    rcnt_d   = RCNT_RATE;
                end else begin
                    rcnt_d = rcnt_q - RW'(1);
                end
            end
            LOCK: begin
                if (!db_q[UP] && !db_q[DN]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        locked_d = (state_d == LOCK);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            dcnt_q    <= '{default: '0};
            state_q   <= IDLE;
            rcnt_q    <= '0;
            step_q    <= 1'b0;
            updown_q  <= 1'b1;
            locked_q  <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            dcnt_q    <= dcnt_d;
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            step_q    <= step_d;
            updown_q  <= updown_d;
            locked_q  <= locked_d;
        end
    end

    assign bus.step   = step_q;
    assign bus.updown = updown_q;
    assign bus.locked = locked_q;
endmodule

// File: tb/tb_updown_step_ctrl.sv
// Directed bench for updown_step_ctrl at default parameters; edge numbers
// count rising edges after the button is first driven.
module tb_updown_step_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;
    logic prev_step;

    updown_step_ctrl_if bus ();

    updown_step_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        bus.up_btn   = 1'b0;
        bus.down_btn = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        prev_step = 1'b0;
    endtask

    task automatic test_reset;
        bus.up_btn   = 1'b0;
        bus.down_btn = 1'b0;
        rst = 1'b1;
        tick();
        checks++; if (bus.step !== 1'b0) $display("FAIL reset step: got %b want 0", bus.step); else passed++;
        checks++; if (bus.updown !== 1'b1) $display("FAIL reset updown: got %b want 1", bus.updown); else passed++;
        checks++; if (bus.locked !== 1'b0) $display("FAIL reset locked: got %b want 0", bus.locked); else passed++;
        rst = 1'b0;
    endtask

    // Held for 12 cycles: one press step at edge 7, released before the first repeat.
    task automatic test_clean_press;
        logic exp_step;
        do_reset();
        bus.up_btn = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            if (e == 13) bus.up_btn = 1'b0;
            tick();
            exp_step = (e == 7);
            checks++; if (bus.step !== exp_step) $display("FAIL clean_press step @%0d: got %b want %b", e, bus.step, exp_step); else passed++;
            if (e == 7) begin
                checks++; if (bus.updown !== 1'b1) $display("FAIL clean_press updown @%0d: got %b want 1", e, bus.updown); else passed++;
            end
        end
    endtask

    // Bounce 1,0,1,0 before edges 1..4, stable from edge 5: step at edge 11.
    task automatic test_bouncy_press;
        logic exp_step;
        do_reset();
        for (int e = 1; e <= 25; e++) begin
            bus.down_btn = (e >= 5) ? 1'b1 : logic'(e % 2);
            tick();
            exp_step = (e == 11);
            checks++; if (bus.step !== exp_step) $display("FAIL bouncy step @%0d: got %b want %b", e, bus.step, exp_step); else passed++;
            if (e >= 11) begin
                checks++; if (bus.updown !== 1'b0) $display("FAIL bouncy updown @%0d: got %b want 0", e, bus.updown); else passed++;
            end
        end
    endtask

    // Direction left at 0 by the down press must return to 1 on reset.
    task automatic test_reset_restores_dir;
        bus.down_btn = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.updown !== 1'b1) $display("FAIL reset_dir updown: got %b want 1", bus.updown); else passed++;
        checks++; if (bus.step !== 1'b0) $display("FAIL reset_dir step: got %b want 0", bus.step); else passed++;
    endtask

    // Held 56 cycles: steps 7,23,31,39,47,55; db falls after edge 62 so no step at 63.
    task automatic test_auto_repeat;
        logic exp_step;
        do_reset();
        bus.up_btn = 1'b1;
        for (int e = 1; e <= 75; e++) begin
            if (e == 57) bus.up_btn = 1'b0;
            tick();
            exp_step = (e == 7) || (e >= 23 && e <= 55 && ((e - 23) % 8 == 0));
            checks++; if (bus.step !== exp_step) $display("FAIL repeat step @%0d: got %b want %b", e, bus.step, exp_step); else passed++;
            checks++; if (bus.updown !== 1'b1) $display("FAIL repeat updown @%0d: got %b want 1", e, bus.updown); else passed++;
            checks++; if (bus.step && prev_step) $display("FAIL repeat spacing @%0d: got 1,1 want no back-to-back", e); else passed++;
            prev_step = bus.step;
        end
    endtask

    // Down joins at edge 20 -> db_dn after 25 -> LOCK at 26; up released (35), then down (50) -> IDLE at 56.
    task automatic test_conflict;
        logic exp_step, exp_locked;
        do_reset();
        bus.up_btn = 1'b1;
        for (int e = 1; e <= 65; e++) begin
            if (e == 20) bus.down_btn = 1'b1;
            if (e == 35) bus.up_btn   = 1'b0;
            if (e == 50) bus.down_btn = 1'b0;
            tick();
            exp_step   = (e == 7) || (e == 23);
            exp_locked = (e >= 26) && (e < 56);
            checks++; if (bus.step !== exp_step) $display("FAIL conflict step @%0d: got %b want %b", e, bus.step, exp_step); else passed++;
            checks++; if (bus.locked !== exp_locked) $display("FAIL conflict locked @%0d: got %b want %b", e, bus.locked, exp_locked); else passed++;
        end
    endtask

    // Both rise on the same edge: LOCK at edge 7 with no step; release at 12 -> IDLE at 18.
    task automatic test_simultaneous;
        logic exp_locked;
        do_reset();
        bus.up_btn   = 1'b1;
        bus.down_btn = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            if (e == 12) begin
                bus.up_btn   = 1'b0;
                bus.down_btn = 1'b0;
            end
            tick();
            exp_locked = (e >= 7) && (e < 18);
            checks++; if (bus.step !== 1'b0) $display("FAIL simultaneous step @%0d: got %b want 0", e, bus.step); else passed++;
            checks++; if (bus.locked !== exp_locked) $display("FAIL simultaneous locked @%0d: got %b want %b", e, bus.locked, exp_locked); else passed++;
        end
    endtask

    // Reset on edge 15 while up is held: fresh press step 7 edges later, at 22.
    task automatic test_reset_mid_hold;
        logic exp_step;
        do_reset();
        bus.up_btn = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            rst = (e == 15);
            tick();
            exp_step = (e == 7) || (e == 22);
            checks++; if (bus.step !== exp_step) $display("FAIL reset_hold step @%0d: got %b want %b", e, bus.step, exp_step); else passed++;
            if (e == 15) begin
                checks++; if (bus.updown !== 1'b1) $display("FAIL reset_hold updown @%0d: got %b want 1", e, bus.updown); else passed++;
                checks++; if (bus.locked !== 1'b0) $display("FAIL reset_hold locked @%0d: got %b want 0", e, bus.locked); else passed++;
            end
        end
        rst = 1'b0;
        bus.up_btn = 1'b0;
    endtask

    initial begin
        bus.up_btn   = 1'b0;
        bus.down_btn = 1'b0;
        prev_step    = 1'b0;
        test_reset();
        test_clean_press();
        test_bouncy_press();
        test_reset_restores_dir();
        test_auto_repeat();
        test_conflict();
        test_simultaneous();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
